// File: rtl/demux7_frame_rx.sv
// Receive side of a slotted serial link: one bit per slot is gathered into a
// parallel word, with start-of-frame resync, framing-error pulses and a frame counter.
module demux7_frame_rx #(
  parameter int NUM_SLOTS = 7,
  parameter int CNT_W     = 8
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_bit_in,
  input  logic                 i_bit_valid,
  input  logic                 i_sof,
  output logic [2:0]           o_slot_out,
  output logic                 o_busy,
  output logic [NUM_SLOTS-1:0] o_word_out,
  output logic                 o_word_valid,
  output logic                 o_sync_err,
  output logic [CNT_W-1:0]     o_frame_count
);

  localparam logic [2:0] LAST_SLOT = 3'(NUM_SLOTS - 1);

  typedef enum logic {S_IDLE, S_COLLECT} state_t;

  state_t               r_state, w_state_next;
  logic [2:0]           r_slot, w_slot_next;
  // The final slot goes straight into the output word, so only slots 0..N-2 are buffered.
  logic [NUM_SLOTS-2:0] r_shadow, w_shadow_next;
  logic [NUM_SLOTS-1:0] r_word, w_word_next, w_word_cand;
  logic                 r_word_valid, w_word_valid_next;
  logic                 r_sync_err, w_sync_err_next;
  logic [CNT_W-1:0]     r_count, w_count_next;
  logic                 w_load_first, w_write_slot;

  always_comb begin
    w_state_next      = r_state;
    w_slot_next       = r_slot;
    w_word_next       = r_word;
    w_word_valid_next = 1'b0;
    w_sync_err_next   = 1'b0;
    w_count_next      = r_count;
    w_load_first      = 1'b0;
    w_write_slot      = 1'b0;
    if (i_bit_valid) begin
      case (r_state)
        S_IDLE: begin
          if (i_sof) begin
            w_load_first = 1'b1;
            w_slot_next  = 3'd1;
            w_state_next = S_COLLECT;
          end else begin
            w_sync_err_next = 1'b1;
          end
        end
        S_COLLECT: begin
          if (i_sof) begin
            // Early start-of-frame: drop the partial word and restart at slot 1.
            w_sync_err_next = 1'b1;
            w_load_first    = 1'b1;
            w_slot_next     = 3'd1;
          end else if (r_slot == LAST_SLOT) begin
            w_word_next       = w_word_cand;
            w_word_valid_next = 1'b1;
            w_count_next      = r_count + CNT_W'(1);
            w_slot_next       = 3'd0;
            w_state_next      = S_IDLE;
          end else begin
            w_write_slot = 1'b1;
            w_slot_next  = r_slot + 3'd1;
          end
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS - 1; gi++) begin : g_shadow
      if (gi == 0) begin : g_first
        assign w_shadow_next[gi] = w_load_first ? i_bit_in : r_shadow[gi];
      end else begin : g_rest
        assign w_shadow_next[gi] = w_load_first ? 1'b0 :
                                   (w_write_slot && r_slot == 3'(gi)) ? i_bit_in :
                                   r_shadow[gi];
      end
    end
  endgenerate

  assign w_word_cand = {i_bit_in, r_shadow};

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_slot       <= 3'd0;
      r_shadow     <= '0;
      r_word       <= '0;
      r_word_valid <= 1'b0;
      r_sync_err   <= 1'b0;
      r_count      <= '0;
    end else begin
      r_state      <= w_state_next;
      r_slot       <= w_slot_next;
      r_shadow     <= w_shadow_next;
      r_word       <= w_word_next;
      r_word_valid <= w_word_valid_next;
      r_sync_err   <= w_sync_err_next;
      r_count      <= w_count_next;
    end
  end

  assign o_slot_out    = r_slot;
  assign o_busy        = (r_state == S_COLLECT);
  assign o_word_out    = r_word;
  assign o_word_valid  = r_word_valid;
  assign o_sync_err    = r_sync_err;
  assign o_frame_count = r_count;

endmodule

// File: tb/tb_demux7_frame_rx.sv
// Bench for demux7_frame_rx: fixed vector table, hand-built corner sequences and
// random traffic, all checked against a queue-based frame model.
module tb_demux7_frame_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic r_reset = 1'b0, r_bit = 1'b0, r_valid = 1'b0, r_sof = 1'b0;

  logic [2:0] a_slot, b_slot;
  logic       a_busy, b_busy, a_wv, b_wv, a_err, b_err;
  logic [6:0] a_word, b_word;
  logic [7:0] a_cnt;
  logic [1:0] b_cnt;

  demux7_frame_rx dut_a (
    .i_clock(clk), .i_reset(r_reset), .i_bit_in(r_bit), .i_bit_valid(r_valid), .i_sof(r_sof),
    .o_slot_out(a_slot), .o_busy(a_busy), .o_word_out(a_word), .o_word_valid(a_wv),
    .o_sync_err(a_err), .o_frame_count(a_cnt));

  demux7_frame_rx #(.NUM_SLOTS(7), .CNT_W(2)) dut_b (
    .i_clock(clk), .i_reset(r_reset), .i_bit_in(r_bit), .i_bit_valid(r_valid), .i_sof(r_sof),
    .o_slot_out(b_slot), .o_busy(b_busy), .o_word_out(b_word), .o_word_valid(b_wv),
    .o_sync_err(b_err), .o_frame_count(b_cnt));

  int total = 0;
  int bad   = 0;

  // Reference model: bits collected so far in the current frame, plus last results.
  bit       m_q[$];
  bit       m_in = 0;
  bit [6:0] m_word = 0;
  int       m_cnt = 0;
  bit       m_wv = 0, m_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model(input bit rst, input bit bv, input bit sof, input bit b);
    m_wv  = 0;
    m_err = 0;
    if (rst) begin
      m_q.delete(); m_in = 0; m_word = 0; m_cnt = 0;
    end else if (bv) begin
      if (sof) begin
        if (m_in) m_err = 1;
        m_q.delete();
        m_q.push_back(b);
        m_in = 1;
      end else if (!m_in) begin
        m_err = 1;
      end else begin
        m_q.push_back(b);
        if (m_q.size() == 7) begin
          m_word = 0;
          foreach (m_q[k]) m_word[k] = m_q[k];
          m_wv = 1;
          m_cnt++;
          m_in = 0;
          m_q.delete();
        end
      end
    end
  endtask

  task automatic step(input bit rst, input bit bv, input bit sof, input bit b);
    int exp_slot;
    r_reset = rst; r_valid = bv; r_sof = sof; r_bit = b;
    @(posedge clk);
    #1;
    model(rst, bv, sof, b);
    exp_slot = m_in ? m_q.size() : 0;
    chk("slot",   32'(a_slot), 32'(exp_slot));
    chk("busy",   32'(a_busy), 32'(m_in));
    chk("word",   32'(a_word), 32'(m_word));
    chk("wvalid", 32'(a_wv),   32'(m_wv));
    chk("syncerr",32'(a_err),  32'(m_err));
    chk("count",  32'(a_cnt),  32'(m_cnt % 256));
    chk("count2", 32'(b_cnt),  32'(m_cnt % 4));
    chk("b_word", 32'(b_word), 32'(m_word));
    if (a_wv) $display("frame done word=%02h count=%0d", a_word, a_cnt);
  endtask

  task automatic send_frame(input logic [6:0] w);
    for (int k = 0; k < 7; k++) step(0, 1, k == 0, w[k]);
  endtask

  typedef struct {
    bit       rst, bv, sof, b;
    bit [2:0] slot;
    bit       busy;
    bit [6:0] word;
    bit       wv, err;
    bit [7:0] cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit rst, bit bv, bit sof, bit b, bit [2:0] slot, bit busy,
                              bit [6:0] word, bit wv, bit err, bit [7:0] cnt);
    vec_t v;
    v.rst = rst; v.bv = bv; v.sof = sof; v.b = b; v.slot = slot; v.busy = busy;
    v.word = word; v.wv = wv; v.err = err; v.cnt = cnt;
    return v;
  endfunction

  initial begin
    // Reset, then frame 1,0,1,1,0,0,1 -> 7'b1001101.
    tbl.push_back(mk(1,0,0,0, 0,0, 7'h00,0,0,0));
    tbl.push_back(mk(0,1,1,1, 1,1, 7'h00,0,0,0));
    tbl.push_back(mk(0,1,0,0, 2,1, 7'h00,0,0,0));
    tbl.push_back(mk(0,1,0,1, 3,1, 7'h00,0,0,0));
    tbl.push_back(mk(0,1,0,1, 4,1, 7'h00,0,0,0));
    tbl.push_back(mk(0,1,0,0, 5,1, 7'h00,0,0,0));
    tbl.push_back(mk(0,1,0,0, 6,1, 7'h00,0,0,0));
    tbl.push_back(mk(0,1,0,1, 0,0, 7'h4D,1,0,1));
    tbl.push_back(mk(0,0,0,0, 0,0, 7'h4D,0,0,1));
    // Stray bit while idle, then sof without valid (ignored).
    tbl.push_back(mk(0,1,0,1, 0,0, 7'h4D,0,1,1));
    tbl.push_back(mk(0,0,1,1, 0,0, 7'h4D,0,0,1));
    // Four bits, then early sof with bit 1, then six zeros.
    tbl.push_back(mk(0,1,1,0, 1,1, 7'h4D,0,0,1));
    tbl.push_back(mk(0,1,0,1, 2,1, 7'h4D,0,0,1));
    tbl.push_back(mk(0,1,0,1, 3,1, 7'h4D,0,0,1));
    tbl.push_back(mk(0,1,0,0, 4,1, 7'h4D,0,0,1));
    tbl.push_back(mk(0,1,1,1, 1,1, 7'h4D,0,1,1));
    for (int s = 2; s <= 6; s++) tbl.push_back(mk(0,1,0,0, 3'(s),1, 7'h4D,0,0,1));
    tbl.push_back(mk(0,1,0,0, 0,0, 7'h01,1,0,2));
    tbl.push_back(mk(0,0,0,0, 0,0, 7'h01,0,0,2));

    @(negedge clk);
    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].bv, tbl[i].sof, tbl[i].b);
      chk("tbl_slot", 32'(a_slot), 32'(tbl[i].slot));
      chk("tbl_busy", 32'(a_busy), 32'(tbl[i].busy));
      chk("tbl_word", 32'(a_word), 32'(tbl[i].word));
      chk("tbl_wv",   32'(a_wv),   32'(tbl[i].wv));
      chk("tbl_err",  32'(a_err),  32'(tbl[i].err));
      chk("tbl_cnt",  32'(a_cnt),  32'(tbl[i].cnt));
    end

    // Gap of three idle cycles after slot 3.
    step(0,1,1,1); step(0,1,0,0); step(0,1,0,1); step(0,1,0,1);
    for (int g = 0; g < 3; g++) begin
      step(0,0,0,0);
      chk("gap_slot", 32'(a_slot), 32'd4);
      chk("gap_busy", 32'(a_busy), 32'd1);
    end
    step(0,1,0,0); step(0,1,0,0); step(0,1,0,1);
    chk("gap_word", 32'(a_word), 32'h4D);
    chk("gap_wv",   32'(a_wv),   32'd1);

    // Back-to-back frames with no idle cycle.
    step(1,0,0,0);
    send_frame(7'h55);
    chk("b2b_word1", 32'(a_word), 32'h55);
    chk("b2b_wv1",   32'(a_wv),   32'd1);
    send_frame(7'h2A);
    chk("b2b_word2", 32'(a_word), 32'h2A);
    chk("b2b_wv2",   32'(a_wv),   32'd1);
    chk("b2b_cnt",   32'(a_cnt),  32'd2);

    // Reset in the middle of a frame.
    step(0,1,1,1); step(0,1,0,1); step(0,1,0,1);
    step(1,1,0,1);
    chk("rst_word", 32'(a_word), 32'd0);
    chk("rst_wv",   32'(a_wv),   32'd0);
    chk("rst_slot", 32'(a_slot), 32'd0);
    chk("rst_cnt",  32'(a_cnt),  32'd0);

    // Five frames: the 2-bit counter wraps to 1.
    for (int f = 0; f < 5; f++) send_frame(7'($urandom_range(0, 127)));
    chk("wrap_cnt2", 32'(b_cnt), 32'd1);
    chk("wrap_cnt8", 32'(a_cnt), 32'd5);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7,
           $urandom_range(0, 99) < 12, 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
